// File: rtl/byte_serial_tx_if.sv
// Load/ready handshake and serial-line signals for byte_serial_tx.
// The master drives d/load and sees ready, sout, busy and done; the DUT is the slave.
interface byte_serial_tx_if;
   logic [7:0] d;
   logic       load;
   logic       ready;
   logic       sout;
   logic       busy;
   logic       done;

   // Handshake: a word on d is taken at a rising clk edge where load && ready;
   // load without ready has no effect, and d is ignored except at that edge.
   modport master (output d, load, input ready, sout, busy, done);
   modport slave  (input d, load, output ready, sout, busy, done);
endinterface

// File: rtl/byte_serial_tx.sv
// Framed byte transmitter: start bit, 8 data bits LSB-first, optional even
// parity, stop bit; each bit held for CLKS_PER_BIT clocks.
module byte_serial_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_EN    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   byte_serial_tx_if.slave  bus,
   output logic [2:0]       state_dbg
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    idx_q, idx_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          parity_q, parity_d;
   logic          sout_q, sout_d;
   logic          done_q, done_d;
   logic          bit_end;

   assign bit_end = (timer_q == TMAX);

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      timer_d  = timer_q;
      parity_d = parity_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (bus.load) begin
               shift_d  = bus.d;
               parity_d = ^bus.d;
               state_d  = S_START;
            end
         end
         S_START: begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
            if (bit_end) begin
               idx_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
            if (bit_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Line level is decided from the next state so sout lands with the state change.
      case (state_d)
         S_START:  sout_d = 1'b0;
         S_DATA:   sout_d = shift_d[0];
         S_PARITY: sout_d = parity_d;
         default:  sout_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
         timer_q  <= '0;
         parity_q <= 1'b0;
         sout_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         timer_q  <= timer_d;
         parity_q <= parity_d;
         sout_q   <= sout_d;
         done_q   <= done_d;
      end
   end

   assign bus.sout  = sout_q;
   assign bus.done  = done_q;
   assign bus.ready = (state_q == S_IDLE);
   assign bus.busy  = (state_q != S_IDLE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Directed bench for byte_serial_tx: one instance at 4 clk/bit with parity,
// one at 1 clk/bit without parity; checks every cycle of each frame.
module tb_byte_serial_tx;

   logic       clk;
   logic       rst;
   logic [2:0] a_state;
   logic [2:0] b_state;
   int         n_cmp;
   int         n_err;

   byte_serial_tx_if a_if ();
   byte_serial_tx_if b_if ();

   byte_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_a (
      .clk       (clk),
      .rst       (rst),
      .bus       (a_if.slave),
      .state_dbg (a_state)
   );

   byte_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_b (
      .clk       (clk),
      .rst       (rst),
      .bus       (b_if.slave),
      .state_dbg (b_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic sample(input int sel, output logic s, output logic r,
                         output logic b, output logic dn);
      if (sel == 0) begin
         s = a_if.sout; r = a_if.ready; b = a_if.busy; dn = a_if.done;
      end else begin
         s = b_if.sout; r = b_if.ready; b = b_if.busy; dn = b_if.done;
      end
   endtask

   task automatic chk_idle(input int sel, input string tag);
      logic s, r, b, dn;
      sample(sel, s, r, b, dn);
      chk({tag, ".sout"}, s, 1'b1);
      chk({tag, ".ready"}, r, 1'b1);
      chk({tag, ".busy"}, b, 1'b0);
      chk({tag, ".done"}, dn, 1'b0);
   endtask

   // Called in the first START cycle; seq holds the nb transmitted bits,
   // first bit in seq[nb-1]. Returns in the done cycle without stepping past it.
   task automatic expect_frame(input int sel, input logic [10:0] seq, input int nb,
                               input int cpb, input string tag);
      logic s, r, b, dn;
      for (int k = 0; k < nb; k++) begin
         for (int c = 0; c < cpb; c++) begin
            sample(sel, s, r, b, dn);
            chk($sformatf("%s.bit%0d.c%0d", tag, k, c), s, seq[nb-1-k]);
            chk($sformatf("%s.busy%0d.c%0d", tag, k, c), b, 1'b1);
            chk($sformatf("%s.ready%0d.c%0d", tag, k, c), r, 1'b0);
            chk($sformatf("%s.done%0d.c%0d", tag, k, c), dn, 1'b0);
            step();
         end
      end
      sample(sel, s, r, b, dn);
      chk({tag, ".done_pulse"}, dn, 1'b1);
      chk({tag, ".ready_after"}, r, 1'b1);
      chk({tag, ".busy_after"}, b, 1'b0);
      chk({tag, ".sout_after"}, s, 1'b1);
   endtask

   task automatic load_a(input logic [7:0] v);
      a_if.d    = v;
      a_if.load = 1'b1;
      step();
      a_if.load = 1'b0;
   endtask

   initial begin
      logic s, r, b, dn;
      n_cmp = 0;
      n_err = 0;
      a_if.d = 8'h00; a_if.load = 1'b0;
      b_if.d = 8'h00; b_if.load = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // idle after reset
      for (int i = 0; i < 5; i++) begin
         chk_idle(0, "idle_a");
         chk_idle(1, "idle_b");
         step();
      end

      // single frame 0xD6 with parity: 0 | 0,1,1,0,1,0,1,1 | 1 | 1
      load_a(8'b11010110);
      expect_frame(0, 11'b00110101111, 11, 4, "d6");
      step();
      chk_idle(0, "d6_post");

      // back-to-back with load held; d changed after acceptance
      a_if.d    = 8'b10011100;
      a_if.load = 1'b1;
      step();
      a_if.d = 8'hFF;
      expect_frame(0, 11'b00011100101, 11, 4, "b2b_1");
      step();
      a_if.load = 1'b0;
      expect_frame(0, 11'b01111111101, 11, 4, "b2b_2");
      step();
      chk_idle(0, "b2b_post");

      // no parity, one clock per bit, 0xA5
      b_if.d    = 8'hA5;
      b_if.load = 1'b1;
      step();
      b_if.load = 1'b0;
      expect_frame(1, 11'b00101001011, 10, 1, "a5");
      step();
      chk_idle(1, "a5_post");

      // reset during data bit 3 of 0x3C
      load_a(8'h3C);
      for (int i = 0; i < 16; i++) step();
      sample(0, s, r, b, dn);
      chk("abort.bit3", s, 1'b1);
      chk("abort.busy", b, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle(0, "abort_rst");
      for (int i = 0; i < 50; i++) begin
         sample(0, s, r, b, dn);
         chk("abort.no_done", dn, 1'b0);
         step();
      end
      load_a(8'h01);
      expect_frame(0, 11'b01000000011, 11, 4, "x01");
      step();
      chk_idle(0, "x01_post");

      // rst and load in the same cycle
      a_if.d    = 8'h00;
      a_if.load = 1'b1;
      rst       = 1'b1;
      step();
      rst       = 1'b0;
      a_if.load = 1'b0;
      chk_idle(0, "rst_load_1");
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle(0, "rst_load_n");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
